// File: rtl/mtsp_fmt_pkg.sv
// Shared pixel-format types and helpers for the FMT stage and its consumers.
package mtsp_fmt_pkg;

  // Bit position of the most significant bit of each RGB565 half in a packed word
  localparam int PIX0_MSB = 31;
  localparam int PIX1_MSB = 15;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Which half of the head word is currently being presented
  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } half_sel_t;

  // Widen each channel by replicating its top bits into the new LSBs,
  // so full-scale stays full-scale and zero stays zero
  function automatic rgb888_t expand565(input rgb565_t p);
    rgb888_t q;
    q.r = {p.r, p.r[4:2]};
    q.g = {p.g, p.g[5:4]};
    q.b = {p.b, p.b[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/mtsp_sync_fifo.sv
// Single-clock FIFO with registered storage, occupancy count and head-of-queue output.
module mtsp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage and write pointer; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances once the head entry has been fully consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + 1'b1;
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level <= '0;
    else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/mtsp_fmt_unpack.sv
// Buffers packed RGB565 pairs from the FMT stage and streams them out as
// individual RGB888 pixels (pixel0 first) on a valid/ready interface.
module mtsp_fmt_unpack
  import mtsp_fmt_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ALPHA      = 8'h00
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          IN_EN,
  input  logic [31:0]                   DIN,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [31:0]                   DOUT,
  output logic                          OUT_LAST,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  input  logic                          CLR_OVF
);

  half_sel_t   state;
  half_sel_t   next_state;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic        transfer;
  logic        pop;
  logic        push;
  logic        ovf_set;
  rgb565_t     half_px;
  rgb888_t     wide_px;

  // A word only leaves once its second pixel has been accepted; a full FIFO
  // can still take a word in the same cycle that frees a slot
  assign transfer = OUT_VALID & OUT_READY;
  assign pop      = transfer & (state == HALF1);
  assign push     = IN_EN & (~full | pop);
  assign ovf_set  = IN_EN & full & ~pop;

  mtsp_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (DIN),
    .full  (full),
    .empty (empty),
    .level (FIFO_LEVEL),
    .head  (head)
  );

  // Half-select state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= HALF0;
    else     state <= next_state;
  end

  // Advance halves on each accepted pixel and expand the selected half
  always_comb begin
    next_state = state;
    OUT_VALID  = ~empty;
    OUT_LAST   = 1'b0;
    DOUT       = '0;
    half_px    = head[PIX0_MSB -: 16];
    case (state)
      HALF0: begin
        if (transfer) next_state = HALF1;
      end
      HALF1: begin
        half_px = head[PIX1_MSB -: 16];
        if (transfer) next_state = HALF0;
      end
      default: next_state = HALF0;
    endcase
    wide_px = expand565(half_px);
    if (OUT_VALID) begin
      DOUT     = {ALPHA, wide_px};
      OUT_LAST = (state == HALF1);
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          OVERFLOW <= 1'b0;
    else if (ovf_set) OVERFLOW <= 1'b1;
    else if (CLR_OVF) OVERFLOW <= 1'b0;
  end

endmodule

// File: tb/tb_mtsp_fmt_unpack.sv
// Directed checks of the RGB565-pair unpacker: expansion, handshake, overflow and reset.
module tb_mtsp_fmt_unpack;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_EN;
  logic [31:0] DIN;
  logic        OUT_READY;
  logic        CLR_OVF;
  logic        OUT_VALID,  OUT_LAST,  OVERFLOW;
  logic [31:0] DOUT;
  logic [2:0]  FIFO_LEVEL;
  logic        a_valid, a_last, a_ovf;
  logic [31:0] a_dout;
  logic [2:0]  a_level;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mtsp_fmt_unpack #(.FIFO_DEPTH(4), .ALPHA(8'h00)) dut (
    .CLK(CLK), .RST(RST), .IN_EN(IN_EN), .DIN(DIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DOUT(DOUT),
    .OUT_LAST(OUT_LAST), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW),
    .CLR_OVF(CLR_OVF)
  );

  // Second instance differing only in ALPHA, fed identically
  mtsp_fmt_unpack #(.FIFO_DEPTH(4), .ALPHA(8'hA5)) dut_alpha (
    .CLK(CLK), .RST(RST), .IN_EN(IN_EN), .DIN(DIN),
    .OUT_VALID(a_valid), .OUT_READY(OUT_READY), .DOUT(a_dout),
    .OUT_LAST(a_last), .FIFO_LEVEL(a_level), .OVERFLOW(a_ovf),
    .CLR_OVF(CLR_OVF)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    IN_EN = 1'b1;
    DIN   = w;
    tick();
    IN_EN = 1'b0;
  endtask

  // Hand-expanded pixels: F800->FF0000, 07E0->00FF00, 001F->0000FF,
  // FFFF->FFFFFF, 0000->000000, 8410->848284
  localparam logic [31:0] W0 = 32'hF800_07E0;
  localparam logic [31:0] W1 = 32'h001F_FFFF;
  localparam logic [31:0] W2 = 32'h0000_8410;
  localparam logic [31:0] W3 = 32'hFFFF_F800;
  localparam logic [31:0] W4 = 32'h07E0_001F;

  logic [31:0] exp_ovf [8];
  logic [31:0] exp_full [7];

  initial begin
    exp_ovf  = '{32'h00FF_0000, 32'h0000_FF00, 32'h0000_00FF, 32'h00FF_FFFF,
                 32'h0000_0000, 32'h0084_8284, 32'h00FF_FFFF, 32'h00FF_0000};
    exp_full = '{32'h00FF_FFFF, 32'h0000_0000, 32'h0084_8284, 32'h00FF_FFFF,
                 32'h00FF_0000, 32'h0000_FF00, 32'h0000_00FF};

    RST = 1'b1; IN_EN = 1'b0; DIN = '0; OUT_READY = 1'b0; CLR_OVF = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_dout",  DOUT, 32'd0);
    chk("rst_last",  32'(OUT_LAST), 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_ovf",   32'(OVERFLOW), 32'd0);
    RST = 1'b0;
    tick();

    // Single word, always ready
    OUT_READY = 1'b1;
    push_word(W0);
    chk("single_valid", 32'(OUT_VALID), 32'd1);
    chk("single_p0", DOUT, 32'h00FF_0000);
    chk("single_last0", 32'(OUT_LAST), 32'd0);
    tick();
    chk("single_p1", DOUT, 32'h0000_FF00);
    chk("single_last1", 32'(OUT_LAST), 32'd1);
    tick();
    chk("single_empty", 32'(OUT_VALID), 32'd0);
    chk("single_level", 32'(FIFO_LEVEL), 32'd0);
    chk("single_dout0", DOUT, 32'd0);

    // Bit replication, with and without alpha
    push_word(32'h001F_8410);
    chk("repl_p0", DOUT, 32'h0000_00FF);
    chk("repl_alpha_p0", a_dout, 32'hA500_00FF);
    tick();
    chk("repl_p1", DOUT, 32'h0084_8284);
    chk("repl_alpha_p1", a_dout, 32'hA584_8284);
    tick();
    chk("repl_empty", 32'(OUT_VALID), 32'd0);

    // Backpressure holds the first pixel steady
    OUT_READY = 1'b0;
    push_word(W0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_dout", DOUT, 32'h00FF_0000);
      chk("bp_hold_last", 32'(OUT_LAST), 32'd0);
      tick();
    end
    OUT_READY = 1'b1;
    chk("bp_rel_p0", DOUT, 32'h00FF_0000);
    tick();
    chk("bp_rel_p1", DOUT, 32'h0000_FF00);
    chk("bp_rel_last", 32'(OUT_LAST), 32'd1);
    tick();
    chk("bp_empty", 32'(OUT_VALID), 32'd0);

    // Overflow: fifth word dropped, first four drain in order
    OUT_READY = 1'b0;
    push_word(W0); push_word(W1); push_word(W2); push_word(W3);
    chk("ovf_level4", 32'(FIFO_LEVEL), 32'd4);
    chk("ovf_not_yet", 32'(OVERFLOW), 32'd0);
    push_word(W4);
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    chk("ovf_level_hold", 32'(FIFO_LEVEL), 32'd4);
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_pix", DOUT, exp_ovf[i]);
      chk("ovf_drain_last", 32'(OUT_LAST), 32'(i % 2));
      tick();
    end
    chk("ovf_drained", 32'(OUT_VALID), 32'd0);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // Full FIFO accepts a word in the same cycle as a pop
    OUT_READY = 1'b0;
    push_word(W0); push_word(W1); push_word(W2); push_word(W3);
    OUT_READY = 1'b1;
    tick();
    chk("fullpop_half1", 32'(OUT_LAST), 32'd1);
    IN_EN = 1'b1;
    DIN   = W4;
    tick();
    IN_EN = 1'b0;
    chk("fullpop_ovf", 32'(OVERFLOW), 32'd0);
    chk("fullpop_level", 32'(FIFO_LEVEL), 32'd4);
    chk("fullpop_head", DOUT, 32'h0000_00FF);
    chk("fullpop_last", 32'(OUT_LAST), 32'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("fullpop_drain", DOUT, exp_full[i]);
      tick();
    end
    chk("fullpop_empty", 32'(OUT_VALID), 32'd0);

    // Asynchronous reset mid-stream, while presenting the second half
    OUT_READY = 1'b0;
    push_word(W0); push_word(W1); push_word(W2);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("mid_last", 32'(OUT_LAST), 32'd1);
    chk("mid_level", 32'(FIFO_LEVEL), 32'd3);
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("arst_ovf",   32'(OVERFLOW), 32'd0);
    chk("arst_dout",  DOUT, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("post_rst_empty", 32'(OUT_VALID), 32'd0);
    OUT_READY = 1'b1;
    push_word(W3);
    chk("post_rst_p0", DOUT, 32'h00FF_FFFF);
    chk("post_rst_last", 32'(OUT_LAST), 32'd0);
    tick();
    chk("post_rst_p1", DOUT, 32'h00FF_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtsp_fmt_unpack.md
Name: mtsp_fmt_unpack

Overview:
- Downstream consumer of the ALU FMT stage. The FMT stage emits one 32-bit word per PHASE_EN pulse; each word holds two RGB565 pixels: pixel0 in [31:16], pixel1 in [15:0].
- This block buffers those words in a small FIFO, serializes each word into two pixels (pixel0 first), and expands each pixel to RGB888 by bit replication.
- Pixels leave on a valid/ready stream toward the pixel writer.
- The FMT stage has no backpressure, so this block's FIFO absorbs stalls. An overflow drops the incoming word and raises a sticky flag.

Parameters:
- FIFO_DEPTH, 4, number of packed-word entries; must be a power of two and at least 2.
- ALPHA, 8'h00, constant placed in DOUT[31:24] of every expanded pixel.

Ports:
- CLK  in  1  main clock.
- RST  in  1  reset, asynchronous, active-high.
- IN_EN  in  1  input word strobe; driven by the FMT stage's PHASE_EN.
- DIN  in  32  packed RGB565 pair; driven by the FMT stage's DOUT.
- OUT_VALID  out  1  pixel available.
- OUT_READY  in  1  downstream accepts the pixel.
- DOUT  out  32  {ALPHA, R8, G8, B8}.
- OUT_LAST  out  1  current pixel is pixel1 (second half) of its word.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- OVERFLOW  out  1  sticky: a word was dropped.
- CLR_OVF  in  1  clears OVERFLOW.

Behaviour:
- Reset (asynchronous, RST=1): pointers=0, FIFO_LEVEL=0, OVERFLOW=0, half-select state=HALF0, memory=0. Consequently OUT_VALID=0, DOUT=0, OUT_LAST=0.
- Write: IN_EN=1 and not full → DIN is stored at the write pointer at the clock edge. Write pointer wraps modulo FIFO_DEPTH.
- Latency: a word written at edge N is presented (OUT_VALID=1) in the cycle after edge N.
- Output path: OUT_VALID = ~empty. DOUT is combinational from the registered head entry and the half-select state. DOUT=0 and OUT_LAST=0 whenever OUT_VALID=0.
- Expansion of a 16-bit half h:
  - R8 = {h[15:11], h[15:13]}
  - G8 = {h[10:5], h[10:9]}
  - B8 = {h[4:0], h[4:2]}
- Handshake: a transfer occurs on a cycle with OUT_VALID & OUT_READY. DOUT and OUT_LAST must stay stable while OUT_VALID=1 and OUT_READY=0.
- State machine:
  - HALF0: presents head[31:16], OUT_LAST=0. On a transfer → HALF1.
  - HALF1: presents head[15:0], OUT_LAST=1. On a transfer → pop head, read pointer+1 (wrapping), → HALF0.
  - No transfer → state holds.
- Full and IN_EN with no same-cycle pop (pop = transfer in HALF1) → word dropped, OVERFLOW←1, FIFO contents unchanged.
- Full and IN_EN with a same-cycle pop → write accepted; FIFO_LEVEL stays FIFO_DEPTH.
- Empty and IN_EN → write only; OUT_VALID rises the next cycle (no bypass).
- Simultaneous write and pop with neither full nor empty → FIFO_LEVEL unchanged.
- CLR_OVF and a new overflow in the same cycle → OVERFLOW stays 1 (set wins).
- OUT_READY held 1 with a continuous input → sustained 2 pixels per word, 1 pixel per cycle. At most 1 word per 2 cycles drains, so a continuous IN_EN eventually overflows; this is expected.
- RST asserted mid-stream → all buffered data is discarded immediately (asynchronous). No partial pixel is emitted after reset release.

Decomposition:
- Shared package mtsp_fmt_pkg holds:
  - typedef rgb565_t (struct r[4:0], g[5:0], b[4:0]).
  - typedef rgb888_t.
  - function expand565 (replication rule above).
  - constants PIX0_MSB=31 and PIX1_MSB=15.
- The FMT stage uses the same typedefs for packing.
- One natural sub-module: mtsp_sync_fifo (parameterized width/depth). Its outputs are full, empty, level, head data; its inputs are push and pop.
- The top block holds the half-select FSM, the expansion, and the overflow flag.

Test Plan:
- Single word, OUT_READY=1: IN_EN with DIN=32'hF800_07E0.
  - Next cycle: DOUT=32'h00FF_0000, OUT_LAST=0.
  - Following cycle: DOUT=32'h0000_FF00, OUT_LAST=1.
  - Then OUT_VALID=0, FIFO_LEVEL=0.
- Replication check: DIN=32'h001F_8410 → pixels 32'h0000_00FF then 32'h0084_8284. With ALPHA=8'hA5, the first pixel is 32'hA500_00FF.
- Backpressure: hold OUT_READY=0 for 5 cycles after one word.
  - DOUT stays 32'h00FF_0000 and OUT_LAST stays 0 throughout.
  - Release OUT_READY → both pixels appear on consecutive cycles.
- Overflow: OUT_READY=0, 5 consecutive IN_EN words with FIFO_DEPTH=4.
  - FIFO_LEVEL reaches 4; OVERFLOW=1 after the 5th word.
  - Draining yields exactly the first 4 words (8 pixels) in order.
  - Pulsing CLR_OVF returns OVERFLOW to 0.
- Full with same-cycle pop: FIFO full, state HALF1, OUT_READY=1, IN_EN=1 in the same cycle → word accepted, OVERFLOW stays 0, FIFO_LEVEL stays 4.
- Reset mid-stream: 3 words queued and state=HALF1, assert RST for 1 cycle → OUT_VALID=0, FIFO_LEVEL=0, OVERFLOW=0 immediately. The next word after release starts at HALF0.
